// File: rtl/me_mvd_pred_if.sv
`default_nettype none
// ============================================================================
//  Module   : me_mvd_pred_if
//  Purpose  : ME-result input stream and MV/MVD output stream of me_mvd_pred.
//  Revision : 1.0  initial release
// ============================================================================
interface me_mvd_pred_if #(
    parameter int MVD_W = 7
) ();
    logic                    frame_start;
    logic                    valid_i;
    logic                    ready_i;
    logic [5:0]              mv_x_i;
    logic [5:0]              mv_y_i;
    logic [15:0]             sad_i;
    logic                    valid_o;
    logic                    ready_o;
    logic signed [MVD_W-1:0] mv_x_o;
    logic signed [MVD_W-1:0] mv_y_o;
    logic signed [MVD_W-1:0] mvd_x_o;
    logic signed [MVD_W-1:0] mvd_y_o;
    logic [15:0]             sad_o;
    logic [7:0]              mb_x_o;
    logic [7:0]              mb_y_o;
    logic                    last_mb_o;

    // Prediction stage side
    modport slave (
        input  frame_start, valid_i, mv_x_i, mv_y_i, sad_i, ready_o,
        output ready_i, valid_o, mv_x_o, mv_y_o, mvd_x_o, mvd_y_o,
               sad_o, mb_x_o, mb_y_o, last_mb_o
    );

    // ME / entropy-coder side
    modport master (
        output frame_start, valid_i, mv_x_i, mv_y_i, sad_i, ready_o,
        input  ready_i, valid_o, mv_x_o, mv_y_o, mvd_x_o, mvd_y_o,
               sad_o, mb_x_o, mb_y_o, last_mb_o
    );
endinterface
`default_nettype wire

// File: rtl/me_mvd_pred.sv
`default_nettype none
// ============================================================================
//  Module   : me_mvd_pred
//  Purpose  : Converts ME positions to signed MVs and emits MVD = MV - median
//             predictor of the left/top/top-right (top-left) neighbours.
//  Revision : 1.0  initial release
// ============================================================================
module me_mvd_pred #(
    parameter int MACRO_DIM  = 4,
    parameter int SEARCH_DIM = 16,
    parameter int MB_COLS    = 8,
    parameter int MB_ROWS    = 8,
    parameter int MVD_W      = 7
) (
    input  wire logic          clk,
    input  wire logic          rst,
    me_mvd_pred_if.slave       bus
);

    localparam int CENTER = (SEARCH_DIM - MACRO_DIM) / 2;
    localparam int IDX_W  = $clog2(MB_COLS);

    typedef logic signed [MVD_W-1:0] mv_t;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRED   = 2'd1,
        ST_OUT    = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam mv_t        C_CENTER = mv_t'(CENTER);
    localparam logic [7:0] C_LAST_X = 8'(MB_COLS - 1);
    localparam logic [7:0] C_LAST_Y = 8'(MB_ROWS - 1);

    function automatic mv_t med3(input mv_t a, input mv_t b, input mv_t c);
        mv_t lo;
        mv_t hi;
        mv_t m2;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m2 = (hi < c) ? hi : c;
        return (lo > m2) ? lo : m2;
    endfunction

    function automatic mv_t mvp_sel(input logic none, input logic only_a,
                                    input mv_t a, input mv_t b, input mv_t c);
        if (none)        return '0;
        else if (only_a) return a;
        else             return med3(a, b, c);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  mb_x_q, mb_x_d, mb_y_q, mb_y_d;
    mv_t         mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [15:0] sad_q, sad_d;
    mv_t         left_x_q, left_x_d, left_y_q, left_y_d;
    mv_t         tl_x_q, tl_x_d, tl_y_q, tl_y_d;
    mv_t         row_buf_x_q [MB_COLS];
    mv_t         row_buf_x_d [MB_COLS];
    mv_t         row_buf_y_q [MB_COLS];
    mv_t         row_buf_y_d [MB_COLS];

    logic        valid_o_q, valid_o_d;
    mv_t         mv_x_o_q, mv_x_o_d, mv_y_o_q, mv_y_o_d;
    mv_t         mvd_x_o_q, mvd_x_o_d, mvd_y_o_q, mvd_y_o_d;
    logic [15:0] sad_o_q, sad_o_d;
    logic [7:0]  mb_x_o_q, mb_x_o_d, mb_y_o_q, mb_y_o_d;
    logic        last_mb_o_q, last_mb_o_d;

    logic [IDX_W-1:0] x_idx, c_idx;
    logic             a_av, b_av, c_av, d_av;
    mv_t              a_x, b_x, c_x, a_y, b_y, c_y;
    mv_t              mvp_x, mvp_y;

    // Neighbour selection; C falls back to the top-left MV in the last column
    always_comb begin
        x_idx = IDX_W'(mb_x_q);
        c_idx = (mb_x_q == C_LAST_X) ? x_idx : x_idx + IDX_W'(1);
        a_av  = (mb_x_q != 8'd0);
        b_av  = (mb_y_q != 8'd0);
        c_av  = b_av && (mb_x_q != C_LAST_X);
        d_av  = b_av && a_av;
        a_x   = a_av ? left_x_q : '0;
        a_y   = a_av ? left_y_q : '0;
        b_x   = b_av ? row_buf_x_q[x_idx] : '0;
        b_y   = b_av ? row_buf_y_q[x_idx] : '0;
        c_x   = c_av ? row_buf_x_q[c_idx] : (d_av ? tl_x_q : '0);
        c_y   = c_av ? row_buf_y_q[c_idx] : (d_av ? tl_y_q : '0);
        mvp_x = mvp_sel(!a_av && !b_av, a_av && !b_av, a_x, b_x, c_x);
        mvp_y = mvp_sel(!a_av && !b_av, a_av && !b_av, a_y, b_y, c_y);
    end

    always_comb begin
        state_d     = state_q;
        mb_x_d      = mb_x_q;
        mb_y_d      = mb_y_q;
        mv_x_d      = mv_x_q;
        mv_y_d      = mv_y_q;
        sad_d       = sad_q;
        left_x_d    = left_x_q;
        left_y_d    = left_y_q;
        tl_x_d      = tl_x_q;
        tl_y_d      = tl_y_q;
        row_buf_x_d = row_buf_x_q;
        row_buf_y_d = row_buf_y_q;
        valid_o_d   = valid_o_q;
        mv_x_o_d    = mv_x_o_q;
        mv_y_o_d    = mv_y_o_q;
        mvd_x_o_d   = mvd_x_o_q;
        mvd_y_o_d   = mvd_y_o_q;
        sad_o_d     = sad_o_q;
        mb_x_o_d    = mb_x_o_q;
        mb_y_o_d    = mb_y_o_q;
        last_mb_o_d = last_mb_o_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    mv_x_d  = mv_t'(MVD_W'(bus.mv_x_i)) - C_CENTER;
                    mv_y_d  = mv_t'(MVD_W'(bus.mv_y_i)) - C_CENTER;
                    sad_d   = bus.sad_i;
                    state_d = ST_PRED;
                end
            end
            ST_PRED: begin
                mv_x_o_d    = mv_x_q;
                mv_y_o_d    = mv_y_q;
                mvd_x_o_d   = mv_x_q - mvp_x;
                mvd_y_o_d   = mv_y_q - mvp_y;
                sad_o_d     = sad_q;
                mb_x_o_d    = mb_x_q;
                mb_y_o_d    = mb_y_q;
                last_mb_o_d = (mb_x_q == C_LAST_X) && (mb_y_q == C_LAST_Y);
                valid_o_d   = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (bus.ready_o) begin
                    valid_o_d = 1'b0;
                    state_d   = ST_UPDATE;
                end
            end
            default: begin
                tl_x_d             = row_buf_x_q[x_idx];
                tl_y_d             = row_buf_y_q[x_idx];
                row_buf_x_d[x_idx] = mv_x_q;
                row_buf_y_d[x_idx] = mv_y_q;
                left_x_d           = mv_x_q;
                left_y_d           = mv_y_q;
                if (mb_x_q == C_LAST_X) begin
                    mb_x_d   = 8'd0;
                    left_x_d = '0;
                    left_y_d = '0;
                    mb_y_d   = (mb_y_q == C_LAST_Y) ? 8'd0 : mb_y_q + 8'd1;
                end else begin
                    mb_x_d = mb_x_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
        endcase

        // Frame restart wins over any handshake in the same cycle
        if (bus.frame_start) begin
            state_d     = ST_IDLE;
            valid_o_d   = 1'b0;
            mb_x_d      = 8'd0;
            mb_y_d      = 8'd0;
            left_x_d    = '0;
            left_y_d    = '0;
            tl_x_d      = '0;
            tl_y_d      = '0;
            row_buf_x_d = row_buf_x_q;
            row_buf_y_d = row_buf_y_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            sad_q       <= '0;
            left_x_q    <= '0;
            left_y_q    <= '0;
            tl_x_q      <= '0;
            tl_y_q      <= '0;
            valid_o_q   <= 1'b0;
            mv_x_o_q    <= '0;
            mv_y_o_q    <= '0;
            mvd_x_o_q   <= '0;
            mvd_y_o_q   <= '0;
            sad_o_q     <= '0;
            mb_x_o_q    <= '0;
            mb_y_o_q    <= '0;
            last_mb_o_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mb_x_q      <= mb_x_d;
            mb_y_q      <= mb_y_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
            sad_q       <= sad_d;
            left_x_q    <= left_x_d;
            left_y_q    <= left_y_d;
            tl_x_q      <= tl_x_d;
            tl_y_q      <= tl_y_d;
            valid_o_q   <= valid_o_d;
            mv_x_o_q    <= mv_x_o_d;
            mv_y_o_q    <= mv_y_o_d;
            mvd_x_o_q   <= mvd_x_o_d;
            mvd_y_o_q   <= mvd_y_o_d;
            sad_o_q     <= sad_o_d;
            mb_x_o_q    <= mb_x_o_d;
            mb_y_o_q    <= mb_y_o_d;
            last_mb_o_q <= last_mb_o_d;
        end
    end

    // Row buffer is never cleared; row 0 masks whatever it holds
    always_ff @(posedge clk) begin
        row_buf_x_q <= row_buf_x_d;
        row_buf_y_q <= row_buf_y_d;
    end

    assign bus.ready_i   = (state_q == ST_IDLE);
    assign bus.valid_o   = valid_o_q;
    assign bus.mv_x_o    = mv_x_o_q;
    assign bus.mv_y_o    = mv_y_o_q;
    assign bus.mvd_x_o   = mvd_x_o_q;
    assign bus.mvd_y_o   = mvd_y_o_q;
    assign bus.sad_o     = sad_o_q;
    assign bus.mb_x_o    = mb_x_o_q;
    assign bus.mb_y_o    = mb_y_o_q;
    assign bus.last_mb_o = last_mb_o_q;

endmodule
`default_nettype wire

// File: tb/tb_me_mvd_pred.sv
`default_nettype none
// ============================================================================
//  Module   : tb_me_mvd_pred
//  Purpose  : Scoreboard bench for me_mvd_pred with a frame-history MVP model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_me_mvd_pred;

    localparam int MB_COLS = 8;
    localparam int MB_ROWS = 8;
    localparam int MVD_W   = 7;
    localparam int CENTER  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_mvd_pred_if #(.MVD_W(MVD_W)) bus ();

    me_mvd_pred #(
        .MACRO_DIM (4),
        .SEARCH_DIM(16),
        .MB_COLS   (MB_COLS),
        .MB_ROWS   (MB_ROWS),
        .MVD_W     (MVD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int mvx; int mvy; int mvdx; int mvdy;
        int sad; int mbx; int mby; int last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   last_cnt = 0;
    int   last_at  = 0;
    int   o_mvx, o_mvy, o_mvdx, o_mvdy, o_mbx, o_mby;
    int   m_x = 0;
    int   m_y = 0;
    int   hist_x [MB_ROWS][MB_COLS];
    int   hist_y [MB_ROWS][MB_COLS];
    int   fx [64];
    int   fy [64];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int hv(input bit is_x, input int y, input int x);
        return is_x ? hist_x[y][x] : hist_y[y][x];
    endfunction

    function automatic int median3(input int a, input int b, input int c);
        int t;
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
        return b;
    endfunction

    // Neighbours come straight from the current frame's MV history
    function automatic int model_mvp(input bit is_x);
        int a, b, c;
        if (m_y == 0) return (m_x == 0) ? 0 : hv(is_x, 0, m_x - 1);
        a = (m_x > 0) ? hv(is_x, m_y, m_x - 1) : 0;
        b = hv(is_x, m_y - 1, m_x);
        if (m_x < MB_COLS - 1) c = hv(is_x, m_y - 1, m_x + 1);
        else                   c = hv(is_x, m_y - 1, m_x - 1);
        return median3(a, b, c);
    endfunction

    task automatic model_push(input int mx, input int my, input int sad);
        exp_t e;
        e.mvx  = mx - CENTER;
        e.mvy  = my - CENTER;
        e.mvdx = e.mvx - model_mvp(1'b1);
        e.mvdy = e.mvy - model_mvp(1'b0);
        e.sad  = sad;
        e.mbx  = m_x;
        e.mby  = m_y;
        e.last = (m_x == MB_COLS - 1 && m_y == MB_ROWS - 1) ? 1 : 0;
        sb.push_back(e);
        hist_x[m_y][m_x] = e.mvx;
        hist_y[m_y][m_x] = e.mvy;
        if (m_x == MB_COLS - 1) begin
            m_x = 0;
            m_y = (m_y == MB_ROWS - 1) ? 0 : m_y + 1;
        end else begin
            m_x++;
        end
    endtask

    task automatic send_mb(input int mx, input int my, input int sad);
        bit done;
        done = 1'b0;
        bus.mv_x_i  = 6'(mx);
        bus.mv_y_i  = 6'(my);
        bus.sad_i   = 16'(sad);
        bus.valid_i = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.ready_i) begin
                model_push(mx, my, sad);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.valid_o) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_out(input bit rnd);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            bus.ready_o = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.valid_o && bus.ready_o) begin
            n_out++;
            if (bus.last_mb_o) begin
                last_cnt++;
                last_at = n_out;
            end
            o_mvx  = $signed(bus.mv_x_o);
            o_mvy  = $signed(bus.mv_y_o);
            o_mvdx = $signed(bus.mvd_x_o);
            o_mvdy = $signed(bus.mvd_y_o);
            o_mbx  = bus.mb_x_o;
            o_mby  = bus.mb_y_o;
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("mv_x",  o_mvx,  e.mvx);
                check("mv_y",  o_mvy,  e.mvy);
                check("mvd_x", o_mvdx, e.mvdx);
                check("mvd_y", o_mvdy, e.mvdy);
                check("sad",   int'(bus.sad_o), e.sad);
                check("mb_x",  o_mbx,  e.mbx);
                check("mb_y",  o_mby,  e.mby);
                check("last",  int'(bus.last_mb_o), e.last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.valid_i     = 1'b0;
        bus.ready_o     = 1'b0;
        bus.mv_x_i      = '0;
        bus.mv_y_i      = '0;
        bus.sad_i       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready_i", int'(bus.ready_i), 1);
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_mv_x",    int'(bus.mv_x_o), 0);
        check("rst_mvd_y",   int'(bus.mvd_y_o), 0);
        check("rst_sad",     int'(bus.sad_o), 0);
        check("rst_mb_x",    int'(bus.mb_x_o), 0);
        check("rst_last",    int'(bus.last_mb_o), 0);

        for (int i = 0; i < 64; i++) begin
            fx[i] = $urandom_range(0, 12);
            fy[i] = $urandom_range(0, 12);
        end
        fx[0] = 8;  fy[0] = 6;
        fx[1] = 5;  fy[1] = 9;
        fx[2] = 10;
        fx[6] = 9;  fx[7] = 11;
        fx[8] = 6;  fy[8] = 6;
        fx[9] = 7;
        fx[14] = 0; fx[15] = 6;

        // MB(0,0): latency of the first result
        send_mb(fx[0], fy[0], 16'h1234);
        check("lat_pred_valid", int'(bus.valid_o), 0);
        @(posedge clk); #1;
        check("lat_out_valid", int'(bus.valid_o), 1);
        bus.ready_o = 1'b1;
        wait_out(1'b0);
        check("t1_mv_x",  o_mvx, 2);
        check("t1_mvd_x", o_mvdx, 2);
        check("t1_mvd_y", o_mvdy, 0);

        for (int i = 1; i < 64; i++) begin
            send_mb(fx[i], fy[i], $urandom_range(0, 65535));
            bus.ready_o = 1'($urandom_range(0, 1));
            wait_out(1'b1);
            if (i == 1) begin
                check("t2_mv_x",  o_mvx, -1);
                check("t2_mvd_x", o_mvdx, -3);
                check("t2_mvd_y", o_mvdy, 3);
            end
            if (i == 8)  check("t3_mb01_mvd_x", o_mvdx, 0);
            if (i == 9)  check("t3_mb11_mvd_x", o_mvdx, 1);
            if (i == 15) check("t4_d_pred_mvd_x", o_mvdx, -3);
        end

        // Output held under backpressure
        bus.ready_o = 1'b0;
        send_mb(6, 6, 16'h00aa);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid_o", int'(bus.valid_o), 1);
            check("hold_ready_i", int'(bus.ready_i), 0);
            if (sb.size() != 0) begin
                check("hold_mvd_x", int'($signed(bus.mvd_x_o)), sb[0].mvdx);
                check("hold_sad",   int'(bus.sad_o), sb[0].sad);
            end
        end
        base = n_out;
        bus.ready_o = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("hold_one_xfer", n_out, base + 1);
        check("hold_valid_low", int'(bus.valid_o), 0);

        // frame_start colliding with the output handshake
        bus.ready_o = 1'b0;
        send_mb(4, 4, 16'h0055);
        wait_valid();
        bus.ready_o     = 1'b1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        model_reset();
        check("fs_valid_o", int'(bus.valid_o), 0);
        check("fs_ready_i", int'(bus.ready_i), 1);
        check("fs_sb_empty", sb.size(), 0);

        last_cnt = 0;
        base     = n_out;
        send_mb(9, 3, 16'h0777);
        wait_out(1'b0);
        check("fs_mb_x",  o_mbx, 0);
        check("fs_mb_y",  o_mby, 0);
        check("fs_mvd_x", o_mvdx, 3);
        check("fs_mvd_y", o_mvdy, -3);
        for (int i = 1; i < 64; i++) begin
            send_mb($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 65535));
            bus.ready_o = 1'($urandom_range(0, 1));
            wait_out(1'b1);
        end
        check("last_count", last_cnt, 1);
        check("last_at_64", last_at, base + 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic model_reset();
        m_x = 0;
        m_y = 0;
    endtask

endmodule
`default_nettype wire
